// File: rtl/rv_hazard_ctrl_if.sv
// Decode-side tags, EX branch outcome and the hazard controls returned to the pipeline.
interface rv_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              validD;
  logic [REG_AW-1:0] rs1D;
  logic [REG_AW-1:0] rs2D;
  logic [REG_AW-1:0] rdD;
  logic              reg_writeD;
  logic              mem_readD;
  logic              mdD;
  logic              branch_takenE;
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic [1:0]        forward_rs1E;
  logic [1:0]        forward_rs2E;
  logic              md_busy;

  // Pipeline side: presents decode tags and the branch outcome, consumes controls.
  modport master (
    output validD, rs1D, rs2D, rdD, reg_writeD, mem_readD, mdD, branch_takenE,
    input  stallF, stallD, stallE, flushD, flushE, flushM,
    input  forward_rs1E, forward_rs2E, md_busy
  );

  // Hazard controller side.
  modport slave (
    input  validD, rs1D, rs2D, rdD, reg_writeD, mem_readD, mdD, branch_takenE,
    output stallF, stallD, stallE, flushD, flushE, flushM,
    output forward_rs1E, forward_rs2E, md_busy
  );
endinterface

// File: rtl/rv_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline.
// Keeps its own E/M/W shadow copies of the in-flight register tags, so it only
// needs decode-stage tags plus the EX branch outcome.
module rv_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 4   // EX residency of a MUL/DIV op, 2..16
) (
  input  logic clk,
  input  logic rst,
  rv_hazard_ctrl_if.slave hz
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

  // E shadow
  logic              e_valid_reg, e_rw_reg, e_mr_reg, e_md_reg;
  logic [REG_AW-1:0] e_rs1_reg, e_rs2_reg, e_rd_reg;
  // M shadow
  logic              m_valid_reg, m_rw_reg, m_mr_reg;
  logic [REG_AW-1:0] m_rd_reg;
  // W shadow
  logic              w_valid_reg, w_rw_reg;
  logic [REG_AW-1:0] w_rd_reg;
  // MUL/DIV residency tracker
  logic [0:0]        md_state_reg, md_state_next;
  logic [3:0]        md_cnt_reg, md_cnt_next;

  logic              branch_eff;
  logic              load_use;
  logic              md_hold;
  logic              flush_e;
  logic              stall_fd;

  logic [1:0][REG_AW-1:0] rs_e;
  logic [1:0][1:0]        fwd_sel;

  // Outputs are forced quiet while reset is held, even if EX signals a branch.
  assign branch_eff = hz.branch_takenE & ~rst;

  assign load_use = e_valid_reg & e_mr_reg & (e_rd_reg != '0) & hz.validD &
                    ((e_rd_reg == hz.rs1D) | (e_rd_reg == hz.rs2D));

  // The op is released in the BUSY cycle whose counter has reached zero.
  assign md_hold = e_valid_reg & e_md_reg &
                   ~((md_state_reg == ST_BUSY) & (md_cnt_reg == 4'd0));

  assign stall_fd = ~branch_eff & (load_use | md_hold);
  assign flush_e  = branch_eff | (load_use & ~md_hold);

  assign hz.stallF  = stall_fd;
  assign hz.stallD  = stall_fd;
  assign hz.stallE  = md_hold;
  assign hz.flushM  = md_hold;
  assign hz.flushD  = branch_eff;
  assign hz.flushE  = flush_e;
  assign hz.md_busy = md_hold;

  assign rs_e[0] = e_rs1_reg;
  assign rs_e[1] = e_rs2_reg;

  // Per-operand forward select: MEM beats WB, loads in MEM and x0 never forward.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic m_hit;
    logic w_hit;
    assign m_hit = m_valid_reg & m_rw_reg & ~m_mr_reg &
                   (m_rd_reg != '0) & (m_rd_reg == rs_e[gi]);
    assign w_hit = w_valid_reg & w_rw_reg &
                   (w_rd_reg != '0) & (w_rd_reg == rs_e[gi]);
    assign fwd_sel[gi] = m_hit ? 2'b10 : (w_hit ? 2'b01 : 2'b00);
  end

  assign hz.forward_rs1E = fwd_sel[0];
  assign hz.forward_rs2E = fwd_sel[1];

  // MUL/DIV FSM next state: load counter on entry, count down, release at zero.
  always_comb begin
    md_state_next = md_state_reg;
    md_cnt_next   = md_cnt_reg;
    case (md_state_reg)
      ST_IDLE: begin
        if (md_hold) begin
          md_cnt_next   = MD_INIT;
          md_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (md_cnt_reg != 4'd0) begin
          md_cnt_next = md_cnt_reg - 4'd1;
        end else begin
          md_state_next = ST_IDLE;
        end
      end
      default: begin
        md_state_next = ST_IDLE;
        md_cnt_next   = 4'd0;
      end
    endcase
  end

  // MUL/DIV FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_state_reg <= ST_IDLE;
      md_cnt_reg   <= 4'd0;
    end else begin
      md_state_reg <= md_state_next;
      md_cnt_reg   <= md_cnt_next;
    end
  end

  // Shadow pipeline advance: W<=M, M<=E or bubble, E holds / bubbles / loads D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_reg <= 1'b0;
      e_rw_reg    <= 1'b0;
      e_mr_reg    <= 1'b0;
      e_md_reg    <= 1'b0;
      e_rs1_reg   <= '0;
      e_rs2_reg   <= '0;
      e_rd_reg    <= '0;
      m_valid_reg <= 1'b0;
      m_rw_reg    <= 1'b0;
      m_mr_reg    <= 1'b0;
      m_rd_reg    <= '0;
      w_valid_reg <= 1'b0;
      w_rw_reg    <= 1'b0;
      w_rd_reg    <= '0;
    end else begin
      w_valid_reg <= m_valid_reg;
      w_rw_reg    <= m_rw_reg;
      w_rd_reg    <= m_rd_reg;
      if (md_hold) begin
        m_valid_reg <= 1'b0;
        m_rw_reg    <= 1'b0;
        m_mr_reg    <= 1'b0;
        m_rd_reg    <= '0;
      end else begin
        m_valid_reg <= e_valid_reg;
        m_rw_reg    <= e_rw_reg;
        m_mr_reg    <= e_mr_reg;
        m_rd_reg    <= e_rd_reg;
        if (flush_e) begin
          e_valid_reg <= 1'b0;
          e_rw_reg    <= 1'b0;
          e_mr_reg    <= 1'b0;
          e_md_reg    <= 1'b0;
          e_rs1_reg   <= '0;
          e_rs2_reg   <= '0;
          e_rd_reg    <= '0;
        end else begin
          e_valid_reg <= hz.validD;
          e_rw_reg    <= hz.reg_writeD;
          e_mr_reg    <= hz.mem_readD;
          e_md_reg    <= hz.mdD;
          e_rs1_reg   <= hz.rs1D;
          e_rs2_reg   <= hz.rs2D;
          e_rd_reg    <= hz.rdD;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Self-checking bench for rv_hazard_ctrl: directed scenarios followed by random
// decode streams, compared against an instruction-level pipeline model.
module tb_rv_hazard_ctrl;
  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_hazard_ctrl_if #(.REG_AW(5)) hz_if ();
  rv_hazard_ctrl #(.REG_AW(5), .MD_LATENCY(MD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz_if)
  );

  typedef struct {
    bit v;
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit mr;
    bit md;
  } ins_t;

  ins_t bubble = '{default: 0};
  ins_t e_m, m_m, w_m;
  int   e_age;        // cycles the instruction in E has already spent there
  bit   last_stall;
  int   n_chk = 0;
  int   n_pass = 0;

  // captured DUT outputs of the most recent cycle
  logic       cap_stallF, cap_stallE, cap_flushD, cap_flushE, cap_busy;
  logic [1:0] cap_fwd1, cap_fwd2;

  task automatic check_eq(string tag, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic ins_t mk(bit v, int rs1, int rs2, int rd, bit rw, bit mr, bit md);
    ins_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rw = rw; t.mr = mr; t.md = md;
    return t;
  endfunction

  function automatic int fwd_exp(int rs);
    if (m_m.v && m_m.rw && !m_m.mr && m_m.rd != 0 && m_m.rd == rs) return 2;
    if (w_m.v && w_m.rw && w_m.rd != 0 && w_m.rd == rs) return 1;
    return 0;
  endfunction

  function automatic logic [10:0] act_vec();
    return {hz_if.stallF, hz_if.stallD, hz_if.stallE, hz_if.flushD, hz_if.flushE,
            hz_if.flushM, hz_if.forward_rs1E, hz_if.forward_rs2E, hz_if.md_busy};
  endfunction

  task automatic model_reset();
    e_m = bubble; m_m = bubble; w_m = bubble;
    e_age = 0;
    last_stall = 1'b0;
  endtask

  // One clock: drive D and branch, check outputs mid-cycle, then advance the model.
  task automatic run_cycle(string tag, ins_t d, bit br);
    bit hold, lu, fe, st;
    logic [10:0] exp_v, got_v;
    @(negedge clk);
    hz_if.validD        = d.v;
    hz_if.rs1D          = 5'(d.rs1);
    hz_if.rs2D          = 5'(d.rs2);
    hz_if.rdD           = 5'(d.rd);
    hz_if.reg_writeD    = d.rw;
    hz_if.mem_readD     = d.mr;
    hz_if.mdD           = d.md;
    hz_if.branch_takenE = br;
    #1;
    hold  = e_m.v && e_m.md && (e_age < MD_LAT - 1);
    lu    = e_m.v && e_m.mr && e_m.rd != 0 && d.v && (e_m.rd == d.rs1 || e_m.rd == d.rs2);
    fe    = br || (lu && !hold);
    st    = !br && (lu || hold);
    exp_v = {st, st, hold, br, fe, hold, 2'(fwd_exp(e_m.rs1)), 2'(fwd_exp(e_m.rs2)), hold};
    got_v = act_vec();
    check_eq(tag, int'(got_v), int'(exp_v));
    cap_stallF = hz_if.stallF;  cap_stallE = hz_if.stallE;
    cap_flushD = hz_if.flushD;  cap_flushE = hz_if.flushE;
    cap_busy   = hz_if.md_busy;
    cap_fwd1   = hz_if.forward_rs1E; cap_fwd2 = hz_if.forward_rs2E;
    $display("[%0t] %s D(v=%0d rs1=%0d rs2=%0d rd=%0d rw=%0d ld=%0d md=%0d) br=%0d out=%03h exp=%03h",
             $time, tag, d.v, d.rs1, d.rs2, d.rd, d.rw, d.mr, d.md, br, got_v, exp_v);
    last_stall = st;
    @(posedge clk);
    w_m = m_m;
    if (hold) begin
      m_m = bubble;
      e_age++;
    end else begin
      m_m   = e_m;
      e_m   = fe ? bubble : d;
      e_age = 0;
    end
  endtask

  ins_t nop, d_cur;
  bit   br_r;
  int   r;

  initial begin
    nop = bubble;
    rst = 1'b1;
    hz_if.validD = 0; hz_if.rs1D = 0; hz_if.rs2D = 0; hz_if.rdD = 0;
    hz_if.reg_writeD = 0; hz_if.mem_readD = 0; hz_if.mdD = 0; hz_if.branch_takenE = 0;
    model_reset();

    // Reset: everything quiet even with a branch request present.
    repeat (2) @(posedge clk);
    @(negedge clk);
    hz_if.branch_takenE = 1'b1;
    hz_if.validD = 1'b1;
    #1;
    check_eq("reset_hold_outputs", int'(act_vec()), 0);
    $display("[%0t] reset held, outputs=%03h", $time, act_vec());
    hz_if.branch_takenE = 1'b0;
    rst = 1'b0;
    run_cycle("first_after_reset", nop, 0);
    check_eq("first_after_reset_zero", int'(act_vec()), 0);

    // RAW distance 1: add x5 then add x6,x5,x7.
    run_cycle("raw1_prod", mk(1, 1, 2, 5, 1, 0, 0), 0);
    run_cycle("raw1_cons", mk(1, 5, 7, 6, 1, 0, 0), 0);
    run_cycle("raw1_ex", nop, 0);
    check_eq("raw1_fwd1", cap_fwd1, 2);
    check_eq("raw1_fwd2", cap_fwd2, 0);
    check_eq("raw1_nostall", cap_stallF, 0);

    // x0 never forwarded; x3 forwarded from WB at distance 2.
    run_cycle("x0_prod", mk(1, 1, 2, 0, 1, 0, 0), 0);
    run_cycle("x0_cons", mk(1, 0, 0, 9, 1, 0, 0), 0);
    run_cycle("x3_prod", mk(1, 1, 2, 3, 1, 0, 0), 0);
    check_eq("x0_fwd1", cap_fwd1, 0);
    check_eq("x0_fwd2", cap_fwd2, 0);
    run_cycle("x3_gap", nop, 0);
    run_cycle("x3_cons", mk(1, 1, 3, 10, 1, 0, 0), 0);
    run_cycle("x3_ex", nop, 0);
    check_eq("x3_fwd2", cap_fwd2, 1);

    // Load-use: lw x4 then add x8,x4,x4.
    run_cycle("lu_load", mk(1, 2, 0, 4, 1, 1, 0), 0);
    run_cycle("lu_stall", mk(1, 4, 4, 8, 1, 0, 0), 0);
    check_eq("lu_stallF", cap_stallF, 1);
    check_eq("lu_flushE", cap_flushE, 1);
    run_cycle("lu_release", mk(1, 4, 4, 8, 1, 0, 0), 0);
    check_eq("lu_released", cap_stallF, 0);
    run_cycle("lu_ex", nop, 0);
    check_eq("lu_fwd1", cap_fwd1, 1);
    check_eq("lu_fwd2", cap_fwd2, 1);

    // MUL x9 holds E for MD_LAT cycles, consumer then sees it from MEM.
    run_cycle("md_issue", mk(1, 1, 2, 9, 1, 0, 1), 0);
    for (int i = 0; i < MD_LAT - 1; i++) begin
      run_cycle("md_hold", mk(1, 9, 1, 11, 1, 0, 0), 0);
      check_eq("md_busy_on", cap_busy, 1);
      check_eq("md_stallE_on", cap_stallE, 1);
    end
    run_cycle("md_exit", mk(1, 9, 1, 11, 1, 0, 0), 0);
    check_eq("md_busy_off", cap_busy, 0);
    check_eq("md_stall_off", cap_stallF, 0);
    run_cycle("md_cons_ex", nop, 0);
    check_eq("md_fwd_mem", cap_fwd1, 2);

    // Branch overrides load-use.
    run_cycle("br_load", mk(1, 2, 0, 4, 1, 1, 0), 0);
    run_cycle("br_lu", mk(1, 4, 4, 8, 1, 0, 0), 1);
    check_eq("br_nostall", cap_stallF, 0);
    check_eq("br_flushD", cap_flushD, 1);
    check_eq("br_flushE", cap_flushE, 1);
    run_cycle("br_after", nop, 0);
    check_eq("br_fwd1", cap_fwd1, 0);
    check_eq("br_fwd2", cap_fwd2, 0);

    // Async reset in the second MD hold cycle.
    run_cycle("rmd_issue", mk(1, 1, 2, 9, 1, 0, 1), 0);
    run_cycle("rmd_hold1", nop, 0);
    @(negedge clk);
    #1;
    check_eq("rmd_busy_before", hz_if.md_busy, 1);
    rst = 1'b1;
    #1;
    check_eq("rmd_reset_outputs", int'(act_vec()), 0);
    $display("[%0t] reset during MD hold, outputs=%03h", $time, act_vec());
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle("rmd_after", nop, 0);
      check_eq("rmd_busy_after", cap_busy, 0);
    end

    // Random decode streams.
    d_cur = nop;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        d_cur.v   = ($urandom_range(0, 99) < 85);
        d_cur.rs1 = $urandom_range(0, 7);
        d_cur.rs2 = $urandom_range(0, 7);
        d_cur.rd  = $urandom_range(0, 7);
        r         = $urandom_range(0, 99);
        d_cur.mr  = (r < 25);
        d_cur.md  = (r >= 25 && r < 37);
        d_cur.rw  = d_cur.mr || d_cur.md || ($urandom_range(0, 99) < 70);
      end
      br_r = ($urandom_range(0, 99) < 10) && !(e_m.v && e_m.md);
      run_cycle("rand", d_cur, br_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rv_hazard_ctrl.md
Name: rv_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Generates the 2-bit forward selects consumed by the EX-stage operand forwarding mux (00 none, 01 WB->EX, 10 MEM->EX).
- Generates load-use stalls, branch flushes and multi-cycle MUL/DIV holds.
- Tracks destination and source register tags of the in-flight instructions in its own E/M/W shadow registers, so it needs only decode-stage tags plus the EX branch outcome.

Parameters:
- REG_AW, 5, register index width.
- MD_LATENCY, 4, EX residency in cycles of a MUL/DIV op; legal range 2..16.

Ports:
- clk  in  1  core clock, all state rising-edge.
- rst  in  1  asynchronous active-high reset.
- validD  in  1  decode stage holds a real instruction.
- rs1D  in  REG_AW  decode source register 1.
- rs2D  in  REG_AW  decode source register 2.
- rdD  in  REG_AW  decode destination register.
- reg_writeD  in  1  decode instruction writes rd.
- mem_readD  in  1  decode instruction is a load.
- mdD  in  1  decode instruction is MUL/DIV (multi-cycle).
- branch_takenE  in  1  EX resolved a taken branch or jump (redirect).
- stallF  out  1  hold PC.
- stallD  out  1  hold IF/ID register.
- stallE  out  1  hold ID/EX register.
- flushD  out  1  clear IF/ID register.
- flushE  out  1  load bubble into ID/EX.
- flushM  out  1  load bubble into EX/MEM.
- forward_rs1E  out  2  operand 1 forward select.
- forward_rs2E  out  2  operand 2 forward select.
- md_busy  out  1  MUL/DIV hold in progress.

Behaviour:
- Shadow state:
  - E holds valid, rs1, rs2, rd, reg_write, mem_read, md.
  - M holds valid, rd, reg_write, mem_read.
  - W holds valid, rd, reg_write.
  - MD FSM {IDLE, BUSY} with a 4-bit counter.
- Reset (async): all shadow valid/reg_write/mem_read/md = 0, FSM = IDLE, counter = 0. All outputs 0 and forward selects 00 for as long as rst is high and in the first cycle after release.
- Forwarding is combinational from registered E/M/W state, per operand rsX:
  - 10 if M.valid & M.reg_write & !M.mem_read & M.rd != 0 & M.rd == rsX.
  - else 01 if W.valid & W.reg_write & W.rd != 0 & W.rd == rsX.
  - else 00.
  - MEM has priority over WB. x0 is never forwarded.
- load_use = E.valid & E.mem_read & E.rd != 0 & validD & (E.rd == rs1D | E.rd == rs2D).
  - Tags are compared even when the decoded instruction does not use rs2; the conservative stall is accepted.
- md_hold = E.valid & E.md & !(FSM == BUSY & counter == 0).
- MD FSM:
  - IDLE with md_hold: counter <= MD_LATENCY-2, go to BUSY.
  - BUSY with counter != 0: decrement counter.
  - BUSY with counter == 0: go to IDLE; the op leaves E this cycle.
  - Result: an MD op occupies E for exactly MD_LATENCY cycles.
  - md_busy = md_hold.
- Output equations:
  - stallF = stallD = !branch_takenE & (load_use | md_hold).
  - stallE = md_hold.
  - flushM = md_hold.
  - flushD = branch_takenE.
  - flushE = branch_takenE | (load_use & !md_hold).
- Shadow advance each cycle:
  - W <= M.
  - M <= bubble if md_hold, else E.
  - E <= hold if md_hold; else bubble if flushE; else D fields, with valid = validD.
- Simultaneous events:
  - A branch and an MD op cannot both be in E. If branch_takenE rises while E holds an MD op, it is ignored; EX never asserts this.
  - load_use and md_hold are mutually exclusive, because E holds a load or an MD op, never both.
  - A branch overrides load_use: no stall, flush D and E.
- Load result in M is never forwarded (mem_read gate). The load-use bubble guarantees the consumer sees it via 01.
- Reset mid-hold aborts the FSM to IDLE and clears all stalls immediately (async).

Test Plan:
- RAW distance 1: add x5 (D, reg_write) then add x6,x5,x7 -> next cycle forward_rs1E=10, forward_rs2E=00, no stall.
- RAW distance 2 with x0: write x0 then use x0, and write x3 then use x3 two cycles later -> x0 case forward 00; x3 case forward_rs2E=01.
- Load-use: lw x4 then add x8,x4,x4 -> one cycle of stallF=stallD=1 and flushE=1; then forward_rs1E=forward_rs2E=01; stalls deassert.
- MUL/DIV, MD_LATENCY=4: mul x9 enters E -> stallF/D/E=1, flushM=1, md_busy=1 for exactly 3 cycles; 4th cycle all deasserted and the op advances to M.
- Branch during load-use: lw x4 in E, consumer in D, branch_takenE=1 same cycle -> stallF=stallD=0, flushD=flushE=1; next cycle forward 00.
- Async reset mid-MD hold: rst pulsed in the 2nd hold cycle -> all outputs 0 immediately; after release, md_busy stays 0.
